// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if: cache request/response and decode-side bundle of the fetch stage
interface fetch_prefetch_queue_if #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4
);
  logic addr_ready;
  logic [XLEN-1:0] addr;
  logic cache_ack;
  logic [XLEN-1:0] inst;
  logic stall;
  logic jal;
  logic branch;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] b_target;
  logic [XLEN-1:0] final_pc;
  logic [XLEN-1:0] final_inst;
  logic final_valid;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  modport master (
    output addr_ready, addr, final_pc, final_inst, final_valid, occupancy,
    input cache_ack, inst, stall, jal, branch, j_target, b_target
  );
  modport slave (
    input addr_ready, addr, final_pc, final_inst, final_valid, occupancy,
    output cache_ack, inst, stall, jal, branch, j_target, b_target
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: single-outstanding instruction fetch with prefetch FIFO, redirects and bubbles
module fetch_prefetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP = 'h13
) (
  input  logic clk,
  input  logic rst_n,
  fetch_prefetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] fpc, fpc_n, req_pc, req_pc_n, tgt, tgt_n, rtarget, dpc;
  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [OW-1:0] occ;
  logic redir, issue, deliver, bypass, push, pop;
  always_comb begin
    redir = bus.jal | bus.branch;
    rtarget = bus.jal ? bus.j_target : bus.b_target;
    issue = state == IDLE && (redir || occ < OW'(DEPTH));
    dpc = state == IDLE ? (redir ? rtarget : fpc) : req_pc;
    deliver = bus.cache_ack && (issue || (state == BUSY && !redir));
    // a redirect empties the FIFO this cycle, so a same-cycle hit may bypass even under stall
    bypass = deliver && (redir || (!bus.stall && occ == '0));
    push = deliver && !bypass;
    pop = !redir && !bus.stall && occ != '0;
    bus.addr_ready = issue;
    bus.addr = issue ? dpc : '0;
    state_n = state == IDLE ? (issue && !bus.cache_ack ? BUSY : IDLE)
            : bus.cache_ack ? IDLE : redir ? DISCARD : state;
    tgt_n = state != IDLE && redir ? rtarget : tgt;
    req_pc_n = issue ? dpc : req_pc;
    fpc_n = deliver ? dpc + XLEN'(4)
          : state != IDLE && bus.cache_ack ? (redir ? rtarget : tgt) : fpc;
  end
  assign bus.occupancy = occ;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {dpc, bus.inst};
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      fpc <= RESET_PC;
      req_pc <= '0;
      tgt <= '0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
      bus.final_pc <= RESET_PC - XLEN'(4);
      bus.final_inst <= NOP;
      bus.final_valid <= 1'b0;
    end else begin
      state <= state_n;
      fpc <= fpc_n;
      req_pc <= req_pc_n;
      tgt <= tgt_n;
      wp <= redir ? '0 : wp + AW'(push);
      rp <= redir ? '0 : rp + AW'(pop);
      occ <= redir ? '0 : occ + OW'(push) - OW'(pop);
      if (redir || !bus.stall) begin
        bus.final_valid <= bypass || pop;
        bus.final_pc <= bypass ? dpc : pop ? mem[rp][2*XLEN-1:XLEN] : bus.final_pc;
        bus.final_inst <= bypass ? bus.inst : pop ? mem[rp][XLEN-1:0] : NOP;
      end
    end
  always_ff @(posedge clk)
    if (rst_n) assert (!(push && occ == OW'(DEPTH)));
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed scenarios with a scoreboard of expected decode-side instructions
module tb_fetch_prefetch_queue;
  localparam logic [31:0] NOP = 32'h13;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic [31:0] q [$];
  fetch_prefetch_queue_if #(.XLEN(32), .DEPTH(4)) ifc ();
  fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [31:0] a);
    return (a << 8) | 32'h33;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic ack, input logic [31:0] d, input logic st);
    ifc.cache_ack = ack;
    ifc.inst = d;
    ifc.stall = st;
  endtask
  task automatic redir(input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt);
    ifc.jal = j;
    ifc.j_target = jt;
    ifc.branch = b;
    ifc.b_target = bt;
  endtask
  task automatic req(input string tag, input logic rdy, input logic [31:0] a);
    #1;
    chk({tag, "_rdy"}, 32'(ifc.addr_ready), 32'(rdy));
    chk({tag, "_addr"}, ifc.addr, rdy ? a : 32'h0);
  endtask
  task automatic tick();
    logic adv;
    logic [31:0] e;
    adv = !ifc.stall || ifc.jal || ifc.branch;
    @(posedge clk);
    #1;
    if (rst_n && adv && ifc.final_valid) begin
      vectors++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra: got pc %h valid, expected bubble", ifc.final_pc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pc", ifc.final_pc, e);
        chk("sb_inst", ifc.final_inst, ins(e));
      end
    end
  endtask
  task automatic hit(input string tag, input logic [31:0] a);
    drv(1'b1, ins(a), 1'b0);
    req(tag, 1'b1, a);
    q.push_back(a);
    tick();
    chk({tag, "_valid"}, 32'(ifc.final_valid), 32'd1);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 32'h0, 1'b0);
    redir(1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_pc", ifc.final_pc, 32'hFFFF_FFFC);
    chk("rst_inst", ifc.final_inst, NOP);
    chk("rst_valid", 32'(ifc.final_valid), 32'd0);
    chk("rst_occ", 32'(ifc.occupancy), 32'd0);
    q.delete();
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    hit("h0", 32'h0);
    hit("h4", 32'h4);
    hit("h8", 32'h8);
    do_reset();
    hit("m0", 32'h0);
    drv(1'b0, 32'h0, 1'b0);
    req("miss_req", 1'b1, 32'h4);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("miss_bubble_valid", 32'(ifc.final_valid), 32'd0);
      chk("miss_bubble_pc", ifc.final_pc, 32'h0);
      if (i < 2) begin
        req("miss_wait", 1'b0, 32'h0);
        tick();
      end
    end
    drv(1'b1, ins(32'h4), 1'b0);
    req("miss_ack", 1'b0, 32'h0);
    q.push_back(32'h4);
    tick();
    chk("miss_done_pc", ifc.final_pc, 32'h4);
    do_reset();
    hit("s0", 32'h0);
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, ins(32'(4 + 4 * i)), 1'b1);
      req("stall_req", i < 4, 32'(4 + 4 * i));
      if (i < 4) q.push_back(32'(4 + 4 * i));
      tick();
      chk("stall_hold_pc", ifc.final_pc, 32'h0);
      chk("stall_hold_valid", 32'(ifc.final_valid), 32'd1);
    end
    chk("stall_occ", 32'(ifc.occupancy), 32'd4);
    drv(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_pc", ifc.final_pc, 32'(4 + 4 * i));
      chk("drain_occ", 32'(ifc.occupancy), 32'(3 - i));
    end
    do_reset();
    redir(1'b1, 32'h20, 1'b0, 32'h0);
    req("jal20", 1'b1, 32'h20);
    tick();
    redir(1'b1, 32'h100, 1'b0, 32'h0);
    req("jal100_busy", 1'b0, 32'h0);
    tick();
    redir(1'b0, 32'h0, 1'b0, 32'h0);
    req("discard_wait", 1'b0, 32'h0);
    tick();
    drv(1'b1, ins(32'h20), 1'b0);
    req("stale_ack", 1'b0, 32'h0);
    tick();
    chk("stale_valid", 32'(ifc.final_valid), 32'd0);
    hit("j100", 32'h100);
    chk("j100_pc", ifc.final_pc, 32'h100);
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, ins(32'(32'h104 + 4 * i)), 1'b1);
      req("fill", 1'b1, 32'(32'h104 + 4 * i));
      q.push_back(32'(32'h104 + 4 * i));
      tick();
    end
    chk("fill_occ", 32'(ifc.occupancy), 32'd2);
    drv(1'b1, ins(32'h300), 1'b1);
    redir(1'b1, 32'h300, 1'b1, 32'h200);
    req("both", 1'b1, 32'h300);
    q.delete();
    q.push_back(32'h300);
    tick();
    chk("both_pc", ifc.final_pc, 32'h300);
    chk("both_valid", 32'(ifc.final_valid), 32'd1);
    chk("both_occ", 32'(ifc.occupancy), 32'd0);
    redir(1'b0, 32'h0, 1'b0, 32'h0);
    drv(1'b0, 32'h0, 1'b0);
    req("miss304", 1'b1, 32'h304);
    tick();
    drv(1'b1, ins(32'h304), 1'b0);
    redir(1'b0, 32'h0, 1'b1, 32'h400);
    req("br_ack", 1'b0, 32'h0);
    tick();
    chk("br_ack_valid", 32'(ifc.final_valid), 32'd0);
    redir(1'b0, 32'h0, 1'b0, 32'h0);
    hit("b400", 32'h400);
    drv(1'b0, 32'h0, 1'b0);
    req("miss404", 1'b1, 32'h404);
    tick();
    rst_n = 1'b0;
    drv(1'b1, ins(32'h404), 1'b0);
    tick();
    chk("midrst_pc", ifc.final_pc, 32'hFFFF_FFFC);
    chk("midrst_valid", 32'(ifc.final_valid), 32'd0);
    chk("midrst_occ", 32'(ifc.occupancy), 32'd0);
    rst_n = 1'b1;
    drv(1'b0, 32'h0, 1'b0);
    req("post_rst", 1'b1, 32'h0);
    tick();
    chk("post_rst_pc", ifc.final_pc, 32'hFFFF_FFFC);
    chk("post_rst_valid", 32'(ifc.final_valid), 32'd0);
    drv(1'b1, ins(32'h0), 1'b0);
    req("post_rst_ack", 1'b0, 32'h0);
    q.push_back(32'h0);
    tick();
    chk("post_rst_first", ifc.final_pc, 32'h0);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
